matmul_sequencer: RTL and testbench

//  Controller for the systolic matrix-multiply array. Accepts one job command,

---
 rtl/matmul_pkg.sv | 25 ++
 rtl/matmul_operand_loader.sv | 76 +++++++
 rtl/matmul_sequencer.sv | 175 +++++++++++++++++
 tb/tb_matmul_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: sizes, dim width, FSM codes.
package matmul_pkg;

  localparam int DATA_W      = 8;
  localparam int BUS_W       = 16;
  localparam int MAX_DIM     = BUS_W / DATA_W;
  localparam int DIM_W       = 2;
  localparam int MATRIX_WORD = MAX_DIM * MAX_DIM * DATA_W;
  localparam int RESULT_WORD = MAX_DIM * MAX_DIM * BUS_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_A    = 3'd1,
    ST_LOAD_B    = 3'd2,
    ST_LOAD_TAIL = 3'd3,
    ST_RUN       = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // A dim field encodes size-1, so it is usable only if it indexes an existing row/column.
  function automatic logic dim_ok(input logic [DIM_W-1:0] d, input int max_dim);
    return int'(d) < max_dim;
  endfunction

endpackage

// File: rtl/matmul_operand_loader.sv
// Streams rows base..base+last_row from operand memory into a flat row register,
// one read per cycle, capturing each word the cycle after its strobe.
module matmul_operand_loader
  import matmul_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ROWS       = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      i_clear,
  input  logic                      i_start,
  input  logic [ADDR_WIDTH-1:0]     i_base,
  input  logic [DIM_W-1:0]          i_last_row,
  input  logic [BUS_WIDTH-1:0]      i_rd_data,
  output logic                      o_rd_en,
  output logic [ADDR_WIDTH-1:0]     o_rd_addr,
  output logic                      o_last,
  output logic [ROWS*BUS_WIDTH-1:0] o_rows
);

  logic                      r_rd_en;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DIM_W-1:0]          r_cnt;
  logic [DIM_W-1:0]          r_idx;
  logic                      r_cap_vld;
  logic [DIM_W-1:0]          r_cap_row;
  logic [ROWS*BUS_WIDTH-1:0] r_rows;
  logic                      w_last;

  // Terminal count: the read being issued this cycle is the final row.
  assign w_last = r_rd_en && (r_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_cap_vld <= 1'b0;
      r_cap_row <= '0;
      r_rows    <= '0;
    end else begin
      r_cap_vld <= r_rd_en;
      r_cap_row <= r_idx;
      if (i_start) begin
        r_rd_en <= 1'b1;
        r_addr  <= i_base;
        r_cnt   <= i_last_row;
        r_idx   <= '0;
      end else if (r_rd_en) begin
        if (w_last) begin
          r_rd_en <= 1'b0;
        end else begin
          r_addr <= r_addr + 1'b1;
          r_cnt  <= r_cnt - 1'b1;
          r_idx  <= r_idx + 1'b1;
        end
      end
      if (i_clear) begin
        r_rows <= '0;
      end else if (r_cap_vld) begin
        for (int r = 0; r < ROWS; r++) begin
          if (int'(r_cap_row) == r) r_rows[r*BUS_WIDTH +: BUS_WIDTH] <= i_rd_data;
        end
      end
    end
  end

  assign o_rd_en   = r_rd_en;
  assign o_rd_addr = r_addr;
  assign o_last    = w_last;
  assign o_rows    = r_rows;

endmodule

// File: rtl/matmul_sequencer.sv
// Job controller for the systolic matmul array: loads A/B rows, runs the array,
// captures result/flags and feeds the previous result back as bias in accumulate mode.
//
// state        | meaning
// ST_IDLE      | waiting for cmd_start_i; latches dims/mode and validates them
// ST_LOAD_A    | issuing A row reads
// ST_LOAD_B    | issuing B row reads (last A capture overlaps the first cycle)
// ST_LOAD_TAIL | capturing the last B row, no read
// ST_RUN       | mul_start_o held high until mul_finish_i
// ST_DONE      | done_o pulse, back to idle
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int A_BASE     = 0,
  parameter int B_BASE     = 4,
  localparam int MAX_D     = BUS_WIDTH / DATA_WIDTH,
  localparam int MAT_W     = MAX_D * MAX_D * DATA_WIDTH,
  localparam int RES_W     = MAX_D * MAX_D * BUS_WIDTH,
  localparam int FLG_W     = MAX_D * MAX_D
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_start_i,
  input  logic [DIM_W-1:0]      cmd_n_dim_i,
  input  logic [DIM_W-1:0]      cmd_k_dim_i,
  input  logic [DIM_W-1:0]      cmd_m_dim_i,
  input  logic                  cmd_mode_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [BUS_WIDTH-1:0]  mem_rd_data_i,
  output logic [MAT_W-1:0]      a_matrix_o,
  output logic [MAT_W-1:0]      b_matrix_o,
  output logic [RES_W-1:0]      c_matrix_o,
  output logic [DIM_W-1:0]      n_dim_o,
  output logic [DIM_W-1:0]      k_dim_o,
  output logic [DIM_W-1:0]      m_dim_o,
  output logic                  mul_start_o,
  output logic                  mul_mode_o,
  input  logic                  mul_finish_i,
  input  logic [RES_W-1:0]      mul_res_i,
  input  logic [FLG_W-1:0]      mul_flags_i,
  output logic [RES_W-1:0]      res_o,
  output logic [FLG_W-1:0]      flags_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  state_t             r_state;
  logic [DIM_W-1:0]   r_n_dim, r_k_dim, r_m_dim;
  logic               r_mode;
  logic               r_mul_start;
  logic               r_done;
  logic               r_err;
  logic [RES_W-1:0]   r_res;
  logic [FLG_W-1:0]   r_flags;

  logic               w_accept, w_illegal;
  logic               w_a_start, w_b_start;
  logic               w_a_rd_en, w_b_rd_en, w_a_last, w_b_last;
  logic [ADDR_WIDTH-1:0] w_a_addr, w_b_addr;

  assign w_accept  = (r_state == ST_IDLE) && cmd_start_i;
  assign w_illegal = !(dim_ok(cmd_n_dim_i, MAX_D) && dim_ok(cmd_k_dim_i, MAX_D) &&
                       dim_ok(cmd_m_dim_i, MAX_D));
  assign w_a_start = w_accept && !w_illegal;
  assign w_b_start = (r_state == ST_LOAD_A) && w_a_last;

  matmul_operand_loader #(
    .BUS_WIDTH (BUS_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ROWS      (MAX_D)
  ) u_load_a (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_clear   (w_accept),
    .i_start   (w_a_start),
    .i_base    (ADDR_WIDTH'(A_BASE)),
    .i_last_row(cmd_n_dim_i),
    .i_rd_data (mem_rd_data_i),
    .o_rd_en   (w_a_rd_en),
    .o_rd_addr (w_a_addr),
    .o_last    (w_a_last),
    .o_rows    (a_matrix_o)
  );

  matmul_operand_loader #(
    .BUS_WIDTH (BUS_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ROWS      (MAX_D)
  ) u_load_b (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_clear   (w_accept),
    .i_start   (w_b_start),
    .i_base    (ADDR_WIDTH'(B_BASE)),
    .i_last_row(r_k_dim),
    .i_rd_data (mem_rd_data_i),
    .o_rd_en   (w_b_rd_en),
    .o_rd_addr (w_b_addr),
    .o_last    (w_b_last),
    .o_rows    (b_matrix_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_n_dim     <= '0;
      r_k_dim     <= '0;
      r_m_dim     <= '0;
      r_mode      <= 1'b0;
      r_mul_start <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_res       <= '0;
      r_flags     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_start_i) begin
            r_n_dim <= cmd_n_dim_i;
            r_k_dim <= cmd_k_dim_i;
            r_m_dim <= cmd_m_dim_i;
            r_mode  <= cmd_mode_i;
            r_err   <= w_illegal;
            if (w_illegal) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_LOAD_A;
            end
          end
        end
        ST_LOAD_A:    if (w_a_last) r_state <= ST_LOAD_B;
        ST_LOAD_B:    if (w_b_last) r_state <= ST_LOAD_TAIL;
        ST_LOAD_TAIL: begin
          r_state     <= ST_RUN;
          r_mul_start <= 1'b1;
        end
        ST_RUN: begin
          if (mul_finish_i) begin
            r_res       <= mul_res_i;
            r_flags     <= mul_flags_i;
            r_mul_start <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The two loaders never read in the same cycle, so a simple OR/select suffices.
  assign mem_rd_en_o   = w_a_rd_en | w_b_rd_en;
  assign mem_rd_addr_o = w_a_rd_en ? w_a_addr : w_b_addr;

  assign c_matrix_o  = r_mode ? r_res : '0;
  assign n_dim_o     = r_n_dim;
  assign k_dim_o     = r_k_dim;
  assign m_dim_o     = r_m_dim;
  assign mul_start_o = r_mul_start;
  assign mul_mode_o  = r_mode;
  assign res_o       = r_res;
  assign flags_o     = r_flags;
  assign busy_o      = (r_state != ST_IDLE);
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: memory model plus a hand-driven array stand-in.
module tb_matmul_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_start_i;
  logic [1:0]  cmd_n_dim_i, cmd_k_dim_i, cmd_m_dim_i;
  logic        cmd_mode_i;
  logic        mem_rd_en_o;
  logic [3:0]  mem_rd_addr_o;
  logic [15:0] mem_rd_data_i;
  logic [31:0] a_matrix_o, b_matrix_o;
  logic [63:0] c_matrix_o;
  logic [1:0]  n_dim_o, k_dim_o, m_dim_o;
  logic        mul_start_o, mul_mode_o, mul_finish_i;
  logic [63:0] mul_res_i;
  logic [3:0]  mul_flags_i;
  logic [63:0] res_o;
  logic [3:0]  flags_o;
  logic        busy_o, done_o, err_o;

  logic [15:0] mem [16];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o];

  matmul_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_start_i(cmd_start_i), .cmd_n_dim_i(cmd_n_dim_i), .cmd_k_dim_i(cmd_k_dim_i),
    .cmd_m_dim_i(cmd_m_dim_i), .cmd_mode_i(cmd_mode_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_data_i(mem_rd_data_i),
    .a_matrix_o(a_matrix_o), .b_matrix_o(b_matrix_o), .c_matrix_o(c_matrix_o),
    .n_dim_o(n_dim_o), .k_dim_o(k_dim_o), .m_dim_o(m_dim_o),
    .mul_start_o(mul_start_o), .mul_mode_o(mul_mode_o), .mul_finish_i(mul_finish_i),
    .mul_res_i(mul_res_i), .mul_flags_i(mul_flags_i),
    .res_o(res_o), .flags_o(flags_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One job: command, load phase, RUN, then either finish or reset abort.
  task automatic do_job(input string tag, input logic [1:0] n, input logic [1:0] k,
                        input logic [1:0] m, input logic mode, input int exp_start,
                        input int exp_reads, input logic [15:0] exp_addrs,
                        input logic [31:0] exp_a, input logic [31:0] exp_b,
                        input logic [63:0] exp_c, input logic [63:0] res,
                        input logic [3:0] flags, input int glitch_cyc, input bit abort);
    int cyc;
    int nrd;
    logic [15:0] addrs;
    cmd_n_dim_i = n; cmd_k_dim_i = k; cmd_m_dim_i = m; cmd_mode_i = mode;
    cmd_start_i = 1'b1;
    tick();
    cmd_start_i = 1'b0;
    chk({tag, " err clr"}, 64'(err_o), 64'd0);
    cyc = 1; nrd = 0; addrs = '0;
    while (!mul_start_o && cyc < 40) begin
      if (mem_rd_en_o) begin
        nrd++;
        addrs = {addrs[11:0], mem_rd_addr_o};
      end
      if (cyc == glitch_cyc) begin
        cmd_start_i = 1'b1; cmd_n_dim_i = 2'd0; cmd_k_dim_i = 2'd0;
        cmd_m_dim_i = 2'd0; cmd_mode_i = ~mode;
      end else begin
        cmd_start_i = 1'b0;
      end
      tick();
      cyc++;
    end
    cmd_start_i = 1'b0;
    chk({tag, " start cycle"}, 64'(cyc), 64'(exp_start));
    chk({tag, " reads"}, 64'(nrd), 64'(exp_reads));
    chk({tag, " addrs"}, 64'(addrs), 64'(exp_addrs));
    chk({tag, " a_matrix"}, 64'(a_matrix_o), 64'(exp_a));
    chk({tag, " b_matrix"}, 64'(b_matrix_o), 64'(exp_b));
    chk({tag, " c_matrix"}, c_matrix_o, exp_c);
    chk({tag, " dims"}, 64'({n_dim_o, k_dim_o, m_dim_o, mul_mode_o}), 64'({n, k, m, mode}));
    chk({tag, " busy run"}, 64'(busy_o), 64'd1);
    tick(); tick();
    chk({tag, " start held"}, 64'({mul_start_o, mem_rd_en_o, done_o}), 64'b100);
    if (abort) begin
      rst_ni = 1'b0;
      tick();
      chk({tag, " abort start"}, 64'(mul_start_o), 64'd0);
      chk({tag, " abort busy"}, 64'(busy_o), 64'd0);
      chk({tag, " abort res"}, res_o, 64'd0);
      rst_ni = 1'b1;
    end else begin
      mul_res_i = res; mul_flags_i = flags; mul_finish_i = 1'b1;
      tick();
      mul_finish_i = 1'b0;
      chk({tag, " done"}, 64'({done_o, busy_o, mul_start_o}), 64'b110);
      chk({tag, " res"}, res_o, res);
      chk({tag, " flags"}, 64'(flags_o), 64'(flags));
      tick();
      chk({tag, " idle"}, 64'({done_o, busy_o}), 64'b00);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    rst_ni = 1'b0; cmd_start_i = 1'b0; cmd_n_dim_i = '0; cmd_k_dim_i = '0; cmd_m_dim_i = '0;
    cmd_mode_i = 1'b0; mul_finish_i = 1'b0; mul_res_i = '0; mul_flags_i = '0;
    tick(); tick(); tick();
    chk("reset ctl", 64'({busy_o, done_o, err_o, mul_start_o, mem_rd_en_o, mul_mode_o}), 64'd0);
    chk("reset res", res_o, 64'd0);
    chk("reset a", 64'(a_matrix_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // finish while idle must not capture
    mul_res_i = 64'hDEAD_BEEF_0000_1234; mul_flags_i = 4'hF; mul_finish_i = 1'b1;
    tick();
    mul_finish_i = 1'b0;
    chk("idle finish res", res_o, 64'd0);
    chk("idle finish flags", 64'({flags_o, busy_o, done_o}), 64'd0);

    mem[0] = 16'h0201; mem[1] = 16'h0403; mem[4] = 16'h0605; mem[5] = 16'h0807;
    do_job("2x2", 2'd1, 2'd1, 2'd1, 1'b0, 6, 4, 16'h0145, 32'h0403_0201, 32'h0807_0605,
           64'd0, 64'h0032_002B_0016_0013, 4'b0000, -1, 1'b0);
    do_job("acc", 2'd1, 2'd1, 2'd1, 1'b1, 6, 4, 16'h0145, 32'h0403_0201, 32'h0807_0605,
           64'h0032_002B_0016_0013, 64'h0064_0056_002C_0026, 4'b0000, -1, 1'b0);

    mem[0] = 16'h00FD; mem[4] = 16'h0005;
    do_job("1x1", 2'd0, 2'd0, 2'd0, 1'b0, 4, 2, 16'h0004, 32'h0000_00FD, 32'h0000_0005,
           64'd0, 64'h0000_0000_0000_FFF1, 4'b0000, -1, 1'b0);

    mem[0] = 16'h8080; mem[4] = 16'h0080; mem[5] = 16'h0080;
    do_job("ovf", 2'd0, 2'd1, 2'd0, 1'b0, 5, 3, 16'h0045, 32'h0000_8080, 32'h0080_0080,
           64'd0, 64'h0000_0000_0000_8000, 4'b0001, -1, 1'b0);

    cmd_n_dim_i = 2'd2; cmd_k_dim_i = 2'd0; cmd_m_dim_i = 2'd0; cmd_mode_i = 1'b0;
    cmd_start_i = 1'b1;
    tick();
    cmd_start_i = 1'b0;
    chk("illegal err", 64'({err_o, done_o, busy_o, mem_rd_en_o}), 64'b1110);
    chk("illegal res kept", res_o, 64'h0000_0000_0000_8000);
    tick();
    chk("illegal sticky", 64'({err_o, done_o, busy_o, mem_rd_en_o}), 64'b1000);

    mem[0] = 16'h0201; mem[1] = 16'h0403; mem[4] = 16'h0605; mem[5] = 16'h0807;
    do_job("glitch abort", 2'd1, 2'd1, 2'd1, 1'b0, 6, 4, 16'h0145, 32'h0403_0201,
           32'h0807_0605, 64'd0, 64'd0, 4'b0000, 3, 1'b1);
    do_job("post reset", 2'd1, 2'd1, 2'd1, 1'b0, 6, 4, 16'h0145, 32'h0403_0201,
           32'h0807_0605, 64'd0, 64'h0032_002B_0016_0013, 4'b0000, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
